// File: rtl/param_systolic_core.sv
// N x N output-stationary systolic matrix-multiply core with internal operand skew,
// valid tagging and drain sequencing; results are read back through a registered port.
module param_systolic_core #(
  parameter int N    = 4,
  parameter int DW   = 16,
  parameter int AW   = 40,
  parameter int KMAX = 256,
  parameter int KW   = $clog2(KMAX + 1),
  parameter int RW   = $clog2(N * N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            signed_mode,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            busy,
  output logic            done,
  input  logic [RW-1:0]   rd_addr,
  output logic [AW-1:0]   rd_data,
  output logic [1:0]      fsm_state
);

  localparam int DCW = $clog2(2 * N);

  // Upstream handshake: a beat transfers on any rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t         state, state_nx;
  logic [KW-1:0]  k_q, beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           sm_q;
  logic           beat, clr, last_beat, drain_end;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;
  assign beat      = in_valid && in_ready;
  assign clr       = (state == IDLE) && start;
  assign last_beat = beat && (beat_cnt == k_q - KW'(1));
  assign drain_end = (drain_cnt == DCW'(2 * N - 2));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (k_len != '0) ? LOAD : DONE;
      LOAD:    if (last_beat) state_nx = DRAIN;
      DRAIN:   if (drain_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      sm_q      <= 1'b0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        k_q      <= k_len;
        sm_q     <= signed_mode;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

  // Skew edge: row i / column j reach the array edge after i / j register stages.
  logic [DW-1:0] a_edge [N];
  logic [DW-1:0] b_edge [N];
  logic          av_edge [N];
  logic          bv_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[0]  = beat ? a_col[DW-1:0] : '0;
      assign b_edge[0]  = beat ? b_row[DW-1:0] : '0;
      assign av_edge[0] = beat;
      assign bv_edge[0] = beat;
    end else begin : g_chain
      logic [DW-1:0] a_d [i];
      logic [DW-1:0] b_d [i];
      logic          av_d [i];
      logic          bv_d [i];
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          for (int d = 0; d < i; d++) begin
            a_d[d]  <= '0;
            b_d[d]  <= '0;
            av_d[d] <= 1'b0;
            bv_d[d] <= 1'b0;
          end
        end else begin
          a_d[0]  <= beat ? a_col[i*DW +: DW] : '0;
          b_d[0]  <= beat ? b_row[i*DW +: DW] : '0;
          av_d[0] <= beat;
          bv_d[0] <= beat;
          for (int d = 1; d < i; d++) begin
            a_d[d]  <= a_d[d-1];
            b_d[d]  <= b_d[d-1];
            av_d[d] <= av_d[d-1];
            bv_d[d] <= bv_d[d-1];
          end
        end
      end
      assign a_edge[i]  = a_d[i-1];
      assign b_edge[i]  = b_d[i-1];
      assign av_edge[i] = av_d[i-1];
      assign bv_edge[i] = bv_d[i-1];
    end
  end

  // PE state, flattened as index i*N + j.
  logic [DW-1:0] pa  [N*N];
  logic [DW-1:0] pb  [N*N];
  logic          pav [N*N];
  logic          pbv [N*N];
  logic [AW-1:0] acc [N*N];

  logic [DW-1:0]         a_in  [N*N];
  logic [DW-1:0]         b_in  [N*N];
  logic                  av_in [N*N];
  logic                  bv_in [N*N];
  logic [AW-1:0]         prod_ext [N*N];
  logic signed [2*DW+1:0] pw;

  always_comb begin
    pw = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) begin
          a_in[i*N+j]  = a_edge[i];
          av_in[i*N+j] = av_edge[i];
        end else begin
          a_in[i*N+j]  = pa[i*N+j-1];
          av_in[i*N+j] = pav[i*N+j-1];
        end
        if (i == 0) begin
          b_in[i*N+j]  = b_edge[j];
          bv_in[i*N+j] = bv_edge[j];
        end else begin
          b_in[i*N+j]  = pb[i*N+j-N];
          bv_in[i*N+j] = pbv[i*N+j-N];
        end
        // One extra top bit turns both signed and unsigned operands into signed values.
        pw = $signed({sm_q & a_in[i*N+j][DW-1], a_in[i*N+j]}) *
             $signed({sm_q & b_in[i*N+j][DW-1], b_in[i*N+j]});
        prod_ext[i*N+j] = AW'(pw);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < N*N; k++) begin
        pa[k]  <= '0;
        pb[k]  <= '0;
        pav[k] <= 1'b0;
        pbv[k] <= 1'b0;
        acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N*N; k++) begin
        pa[k]  <= a_in[k];
        pb[k]  <= b_in[k];
        pav[k] <= av_in[k];
        pbv[k] <= bv_in[k];
        if (av_in[k] && bv_in[k]) acc[k] <= acc[k] + prod_ext[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || busy) rd_data <= '0;
    else if (int'(rd_addr) < N * N) rd_data <= acc[rd_addr];
    else rd_data <= '0;
  end

endmodule

// File: tb/tb_param_systolic_core.sv
// Directed bench for param_systolic_core (N=4): scoreboard of expected C values,
// handshake/latency checks, zero-length, start-while-busy and mid-operation reset.
module tb_param_systolic_core;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int KW = 9;
  localparam int RW = 4;

  logic            clk = 1'b0;
  logic            rst, start, signed_mode, in_valid;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_col, b_row;
  logic            in_ready, busy, done;
  logic [RW-1:0]   rd_addr;
  logic [AW-1:0]   rd_data;
  logic [1:0]      fsm_state;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] am [N][8];
  logic [DW-1:0] bm [8][N];

  param_systolic_core #(.N(N), .DW(DW), .AW(AW), .KMAX(256)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .a_col(a_col), .b_row(b_row), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .fsm_state(fsm_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data setup
  task automatic set_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) am[i][k] = (i == k) ? 16'd1 : 16'd0;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < N; j++) bm[k][j] = DW'(4 * k + j + 1);
  endtask

  task automatic set_const(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) begin
        am[i][k] = a;
        bm[k][i] = b;
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) begin
        am[i][k] = DW'($urandom_range(0, 65535));
        bm[k][i] = DW'($urandom_range(0, 65535));
      end
  endtask

  // Scoreboard: reference product of the stored matrices
  task automatic push_expected(input int k, input bit sm);
    longint s, x, y;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          x = sm ? longint'($signed(am[i][kk])) : longint'({48'd0, am[i][kk]});
          y = sm ? longint'($signed(bm[kk][j])) : longint'({48'd0, bm[kk][j]});
          s = s + x * y;
        end
        exp_q.push_back(s[AW-1:0]);
      end
  endtask

  task automatic push_zeros();
    for (int n = 0; n < N * N; n++) exp_q.push_back('0);
  endtask

  task automatic read_all(input string tag);
    logic [AW-1:0] e;
    for (int a = 0; a < N * N; a++) begin
      rd_addr = RW'(a);
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("%s_c%0d", tag, a), rd_data, e);
    end
  endtask

  // Driver: one full operation; alt drops in_valid on odd cycles, poke issues
  // start during LOAD, DRAIN and the DONE cycle.
  task automatic run_op(input int k, input bit sm, input bit alt, input bit poke, input string tag);
    int  beats, rdy, cyc, lat, exp_rdy;
    bit  acc_now;
    start = 1'b1; k_len = KW'(k); signed_mode = sm;
    push_expected(k, sm);
    @(negedge clk);
    start = 1'b0;
    beats = 0; rdy = 0; cyc = 0;
    while (beats < k && cyc < 100) begin
      in_valid = alt ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = am[i][beats];
        b_row[i*DW +: DW] = bm[beats][i];
      end
      start = (poke && beats == 1);
      k_len = poke ? '0 : KW'(k);
      if (in_ready) rdy++;
      acc_now = in_valid && in_ready;
      @(negedge clk);
      start = 1'b0;
      if (acc_now) beats++;
      cyc++;
    end
    in_valid = 1'b0; a_col = '0; b_row = '0;
    check({tag, "_beats"}, AW'(beats), AW'(k));
    check({tag, "_ready_fell"}, AW'(in_ready), '0);
    lat = 1;
    while (!done && lat < 50) begin
      if (in_ready) rdy++;
      if (lat == 4 && k > 0) check({tag, "_rd_busy"}, rd_data, '0);
      start = (poke && lat == 3);
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, AW'(lat), (k == 0) ? AW'(1) : AW'(2 * N));
    exp_rdy = (k == 0) ? 0 : (alt ? 2 * k - 1 : k);
    check({tag, "_ready_cycles"}, AW'(rdy), AW'(exp_rdy));
    start = poke; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse"}, AW'(done), '0);
    check({tag, "_idle"}, AW'(busy), '0);
    read_all(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; in_valid = 1'b0;
    a_col = '0; b_row = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", AW'(in_ready), '0);
    check("rst_busy", AW'(busy), '0);
    check("rst_done", AW'(done), '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_state", AW'(fsm_state), '0);
    rst = 1'b0;
    @(negedge clk);

    set_identity();
    run_op(4, 1'b0, 1'b0, 1'b0, "ident");
    run_op(4, 1'b0, 1'b1, 1'b0, "bpress");

    set_const(16'hFFFF, 16'd2);
    run_op(3, 1'b1, 1'b0, 1'b0, "signed");
    run_op(3, 1'b0, 1'b0, 1'b0, "unsigned");

    set_identity();
    run_op(4, 1'b0, 1'b0, 1'b0, "ident2");
    run_op(0, 1'b0, 1'b0, 1'b0, "zero_len");

    run_op(4, 1'b0, 1'b0, 1'b1, "start_busy");

    set_random();
    run_op(5, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand_a");
    run_op(8, 1'b1, 1'b1, 1'b0, "rand_b");

    // Reset in the middle of LOAD after two beats
    set_identity();
    start = 1'b1; k_len = KW'(4); signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = am[i][b];
        b_row[i*DW +: DW] = bm[b][i];
      end
      @(negedge clk);
    end
    in_valid = 1'b0; a_col = '0; b_row = '0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", AW'(busy), '0);
    check("mid_rst_ready", AW'(in_ready), '0);
    check("mid_rst_done", AW'(done), '0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_done2", AW'(done), '0);
    push_zeros();
    read_all("mid_rst");
    run_op(4, 1'b0, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
